// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 memory subsystem: arbiter FSM state
// encoding and memory access width codes.
package raisin64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE  = 2'd0,
    WIDTH_HALF  = 2'd1,
    WIDTH_WORD  = 2'd2,
    WIDTH_DWORD = 2'd3
  } mem_width_e;

  // Latency counter width; covers MEM_LATENCY up to 15.
  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional strict priority for port 0. The grant is
// combinational; the last-grant pointer advances only when a grant is taken.
module rr_arbiter
  import raisin64_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter bit          PRIO_EN   = 1'b1,
  localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_update,
  output logic                 o_grant_valid,
  output logic [IDX_W-1:0]     o_grant_idx
);

  localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Search starts just after the last granted port and wraps once.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    if (PRIO_EN && i_req[0]) begin
      w_found = 1'b1;
      w_idx   = '0;
    end else begin
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        w_sum  = {1'b0, r_last} + (IDX_W+1)'(k) + (IDX_W+1)'(1);
        w_cand = (w_sum >= NP) ? (w_sum - NP) : w_sum;
        if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
          w_found = 1'b1;
          w_idx   = w_cand[IDX_W-1:0];
        end else begin
          w_idx   = w_idx;
        end
      end
    end
  end

  assign o_grant_valid = w_found;
  assign o_grant_idx   = w_idx;

  // Last-grant pointer; reset value makes port 0 the first candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDX_W'(NUM_PORTS - 1);
    end else if (i_update && w_found) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto a single shared RAM port. One
// transaction at a time: IDLE (arbitrate) -> ACCESS (cs + latency) -> DONE (ack).
module mem_port_arbiter
  import raisin64_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned PRIO_PORT0  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [2*NUM_PORTS-1:0]      width,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [DATA_W*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        mem_cs,
  output logic                        mem_we,
  output logic [1:0]                  mem_width,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_e             r_state;
  arb_state_e             w_next;
  logic                   w_grant_valid;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_start;
  logic                   w_lat_done;
  logic [IDX_W-1:0]       r_sel;
  logic [LAT_CNT_W-1:0]   r_cnt;
  logic [NUM_PORTS-1:0]   r_ack;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_busy;
  logic                   r_mem_cs;
  logic                   r_mem_we;
  logic [1:0]             r_mem_width;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PRIO_EN   (PRIO_PORT0 != 0)
  ) u_rr_arbiter (
    .clk           (clk),
    .rst           (rst),
    .i_req         (req),
    .i_update      (w_start),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_start    = (r_state == ST_IDLE) && w_grant_valid;
  assign w_lat_done = (r_state == ST_ACCESS) && (r_cnt == LAT_CNT_W'(MEM_LATENCY));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_grant_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next = w_lat_done ? ST_DONE : ST_ACCESS;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request latch, latency counter, read capture and registered outputs.
  // mem_cs/mem_we are registered off the grant so they cover the first
  // ACCESS cycle only; ack is registered off latency expiry so it covers DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_width <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_busy   <= (w_next != ST_IDLE);
      r_mem_cs <= w_start;
      r_mem_we <= w_start && we[w_grant_idx];
      r_ack    <= '0;
      if (w_start) begin
        r_sel       <= w_grant_idx;
        r_cnt       <= '0;
        r_mem_width <= width[2*int'(w_grant_idx) +: 2];
        r_mem_addr  <= addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
        r_mem_wdata <= wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
      end else if (w_lat_done) begin
        r_rdata <= mem_rdata;
        r_ack   <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_sel;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + LAT_CNT_W'(1);
      end
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_width = r_mem_width;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (latency 1, port-0 priority) runs a per-cycle vector
// table; dut_b (latency 4, pure round-robin) runs hand-written sequences.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   we;
  logic [5:0]   width;
  logic [191:0] addr;
  logic [191:0] wdata;

  logic [2:0]  ack_a, ack_b;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, cs_a, cs_b, mwe_a, mwe_b;
  logic [1:0]  mwidth_a, mwidth_b;
  logic [63:0] maddr_a, maddr_b, mwdata_a, mwdata_b, mrdata_a, mrdata_b;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_PORTS(3), .ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1), .PRIO_PORT0(1)
  ) dut_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .width(width), .addr(addr),
    .wdata(wdata), .ack(ack_a), .rdata(rdata_a), .busy(busy_a),
    .mem_cs(cs_a), .mem_we(mwe_a), .mem_width(mwidth_a), .mem_addr(maddr_a),
    .mem_wdata(mwdata_a), .mem_rdata(mrdata_a)
  );

  mem_port_arbiter #(
    .NUM_PORTS(3), .ADDR_W(64), .DATA_W(64), .MEM_LATENCY(4), .PRIO_PORT0(0)
  ) dut_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .width(width), .addr(addr),
    .wdata(wdata), .ack(ack_b), .rdata(rdata_b), .busy(busy_b),
    .mem_cs(cs_b), .mem_we(mwe_b), .mem_width(mwidth_b), .mem_addr(maddr_b),
    .mem_wdata(mwdata_b), .mem_rdata(mrdata_b)
  );

  // RAM content: 0x10 holds 0xDEAD, everything else reads back as ~addr.
  function automatic logic [63:0] mem_f(input logic [63:0] a);
    return (a == 64'h10) ? 64'hDEAD : ~a;
  endfunction

  // RAM models: data valid exactly MEM_LATENCY cycles after the cs cycle.
  logic [63:0] pipe_a;
  logic [63:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_a     <= cs_a ? mem_f(maddr_a) : GARBAGE;
    pipe_b[0]  <= cs_b ? mem_f(maddr_b) : GARBAGE;
    pipe_b[1]  <= pipe_b[0];
    pipe_b[2]  <= pipe_b[1];
    pipe_b[3]  <= pipe_b[2];
  end
  assign mrdata_a = pipe_a;
  assign mrdata_b = pipe_b[3];

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  exp_ack;
    logic        exp_busy;
    logic        exp_cs;
    logic        exp_mwe;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [1:0]  exp_width;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_duts();
    rst = 1'b1;
    req = 3'b000;
    we  = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next ack on dut_b and checks port and edge count.
  task automatic wait_ack_b(input string name, input logic [2:0] exp_ack, input int exp_n);
    int n = 0;
    logic [2:0] got = 3'b000;
    while (n < 20 && got == 3'b000) begin
      tick();
      n++;
      got = ack_b;
    end
    chk({name, "_ack"}, 64'(got), 64'(exp_ack));
    chk({name, "_lat"}, 64'(n), 64'(exp_n));
    chk({name, "_busy"}, 64'(busy_b), 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 3'b000;
    we    = 3'b000;
    width = {2'h0, 2'h3, 2'h3};
    addr  = {64'h20, 64'h10, 64'h00};
    wdata = {64'h1234, 64'h0, 64'h0};

    //           rst   req     we      ack     bsy   cs    mwe   addr    wdata     wid   chk   rdata
    vecs[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b1, 64'h0};
    vecs[1]  = '{1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 64'h10, 64'h0,    2'h0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 3'b010, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b1, 64'hDEAD};
    vecs[4]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b1, 64'hDEAD};
    vecs[5]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 64'h00, 64'h0,    2'h0, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b1, ~64'h0};
    vecs[8]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 64'h00, 64'h0,    2'h0, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[11] = '{1'b0, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 1'b1, 64'h20, 64'h1234, 2'h0, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[15] = '{1'b0, 3'b100, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,    2'h0, 1'b0, 64'h0};

    // Per-cycle table on dut_a: reset, single read, priority, write.
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      we  = vecs[i].we;
      tick();
      chk($sformatf("v%0d_ack", i),  64'(ack_a),  64'(vecs[i].exp_ack));
      chk($sformatf("v%0d_busy", i), 64'(busy_a), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_cs", i),   64'(cs_a),   64'(vecs[i].exp_cs));
      chk($sformatf("v%0d_mwe", i),  64'(mwe_a),  64'(vecs[i].exp_mwe));
      if (vecs[i].exp_cs) chk($sformatf("v%0d_addr", i), maddr_a, vecs[i].exp_addr);
      if (vecs[i].exp_mwe) begin
        chk($sformatf("v%0d_wdata", i), mwdata_a, vecs[i].exp_wdata);
        chk($sformatf("v%0d_width", i), 64'(mwidth_a), 64'(vecs[i].exp_width));
      end
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata_a, vecs[i].exp_rd);
    end

    // dut_b, latency 4: ack 6 edges after req, busy throughout, single ack.
    reset_duts();
    req = 3'b001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("lat4_busy_e%0d", e), 64'(busy_b), 64'd1);
      chk($sformatf("lat4_ack_e%0d", e), 64'(ack_b), (e == 6) ? 64'd1 : 64'd0);
      chk($sformatf("lat4_cs_e%0d", e), 64'(cs_b), (e == 1) ? 64'd1 : 64'd0);
    end
    req = 3'b000;
    chk("lat4_rdata", rdata_b, ~64'h0);
    tick();
    chk("lat4_ack_after", 64'(ack_b), 64'd0);
    chk("lat4_busy_after", 64'(busy_b), 64'd0);

    // dut_b, round-robin contention between ports 1 and 2.
    reset_duts();
    req = 3'b110;
    wait_ack_b("rr1", 3'b010, 6);
    wait_ack_b("rr2", 3'b100, 7);
    wait_ack_b("rr3", 3'b010, 7);
    req = 3'b000;
    tick();
    chk("rr_ack_clear", 64'(ack_b), 64'd0);

    // dut_b, reset during ACCESS: no ack, cs drops, pointer restarts at 0.
    reset_duts();
    req = 3'b010;
    tick();
    chk("rst_cs_start", 64'(cs_b), 64'd1);
    chk("rst_addr_start", maddr_b, 64'h10);
    tick();
    rst = 1'b1;
    req = 3'b111;
    tick();
    chk("rst_cs", 64'(cs_b), 64'd0);
    chk("rst_busy", 64'(busy_b), 64'd0);
    chk("rst_ack", 64'(ack_b), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_regrant_cs", 64'(cs_b), 64'd1);
    chk("rst_regrant_addr", maddr_b, 64'h00);
    wait_ack_b("rst_regrant", 3'b001, 5);
    req = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, address width.
REQ-003 SHALL have parameter DATA_W, default 64, data width.
REQ-004 SHALL have parameter MEM_LATENCY, default 1, cycles from mem_cs to valid mem_rdata (1..15).
REQ-005 SHALL have parameter PRIO_PORT0, default 1; 1 = port 0 (debug) strict priority, 0 = pure round-robin.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port req  in  NUM_PORTS  per-port access request.
REQ-009 SHALL have port we  in  NUM_PORTS  per-port write enable.
REQ-010 SHALL have port width  in  2*NUM_PORTS  per-port write width code, port i at bits [2i+1:2i].
REQ-011 SHALL have port addr  in  ADDR_W*NUM_PORTS  per-port address, packed port-major.
REQ-012 SHALL have port wdata  in  DATA_W*NUM_PORTS  per-port write data, packed port-major.
REQ-013 SHALL have port ack  out  NUM_PORTS  one-cycle completion pulse per port.
REQ-014 SHALL have port rdata  out  DATA_W  read data, shared, valid when any ack is high.
REQ-015 SHALL have port busy  out  1  high while a transaction is in flight.
REQ-016 SHALL have ports mem_cs, mem_we (out 1), mem_width (out 2), mem_addr (out ADDR_W), mem_wdata (out DATA_W), mem_rdata (in DATA_W): single shared RAM port.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 In IDLE with any req high, SHALL select one port, register its we/width/addr/wdata, and enter ACCESS next cycle.
REQ-019 With PRIO_PORT0=1, SHALL grant port 0 whenever req[0] is high; remaining ports round-robin.
REQ-020 Round-robin SHALL start the search at the port after the last granted port, wrapping NUM_PORTS-1 -> 0.
REQ-021 In ACCESS, SHALL drive mem_cs=1 and the latched controls for exactly one cycle, then count MEM_LATENCY cycles.
REQ-022 mem_we SHALL be high only during the mem_cs cycle of a write.
REQ-023 When the latency count expires, SHALL capture mem_rdata into rdata and enter DONE.
REQ-024 In DONE, SHALL pulse ack[granted]=1 for exactly one cycle, then return to IDLE.
REQ-025 Latency req-high (IDLE) to ack SHALL be MEM_LATENCY+2 cycles.
REQ-026 Requesters SHALL hold req and signals stable until ack; req still high the cycle after ack SHALL be treated as a new request.
REQ-027 SHALL ignore req deassertion after grant; the transaction always completes.
REQ-028 Writes SHALL also complete with ack; rdata for a write is don't-care.
REQ-029 At most one ack bit SHALL be high in any cycle.
REQ-030 busy SHALL be high in ACCESS and DONE, low in IDLE.

Reset
REQ-031 On rst, SHALL enter IDLE; ack=0, busy=0, mem_cs=0, mem_we=0, rdata=0, last-grant pointer=NUM_PORTS-1.
REQ-032 rst asserted mid-transaction SHALL abort it with no ack issued.

Structure
REQ-033 FSM state encoding and width codes (byte/half/word/dword) SHALL live in shared package raisin64_pkg.
REQ-034 Arbitration logic SHALL be sub-module rr_arbiter (NUM_PORTS, priority-port enable), combinational grant plus registered pointer.

Verification
REQ-035 Single read: port 1 req, addr=0x10, MEM_LATENCY=1, mem_rdata=0xDEAD -> ack[1] at cycle 3, rdata=0xDEAD.
REQ-036 Contention: ports 1,2 req together, PRIO_PORT0=0 -> grants 1 then 2, then 1 again if still requesting.
REQ-037 Priority: ports 0,1,2 requesting continuously, PRIO_PORT0=1 -> port 0 granted every transaction; ports 1/2 starve.
REQ-038 Write: port 2 we=1, width=2'h0, addr=0x20, wdata=0x1234 -> one mem_cs cycle with mem_we=1 and matching bus, then ack[2].
REQ-039 Reset mid-op: rst asserted in ACCESS -> no ack, mem_cs=0 next cycle, next grant goes to port 0.
REQ-040 MEM_LATENCY=4 -> ack exactly 6 cycles after req; no double ack; busy covers the whole window.
